// File: rtl/dsi_pkg.sv
// Shared DSI definitions: packet classification, splitter FSM encoding,
// FIFO tag values and CRC seed.
package dsi_pkg;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2
    } split_state_e;

    localparam logic [1:0]  TAG_PAYLOAD = 2'b00;
    localparam logic [1:0]  TAG_SHORT   = 2'b01;
    localparam logic [1:0]  TAG_LONG    = 2'b10;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;

    function automatic logic is_long_type(input logic [7:0] di);
        return (di[7:2] == 6'h0E) || (di[7:2] == 6'h09);
    endfunction

    // Keeps the low n bytes of a word, clears the rest.
    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < n) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_aligner.sv
// 8-byte realignment buffer: drops consumed bytes from the bottom and appends
// accepted stream words directly above whatever remains.
module byte_aligner (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] stream_data_i,
    input  logic        stream_valid_i,
    output logic        stream_read_o,
    input  logic [2:0]  consume_i,
    output logic [31:0] align_word_o,
    output logic [3:0]  align_cnt_o
);

    logic [63:0] align_buf_q, align_buf_d;
    logic [3:0]  align_cnt_q, align_cnt_d;
    logic [3:0]  remain;

    assign stream_read_o = stream_valid_i && (align_cnt_q <= 4'd4) && reset_n;
    assign align_word_o  = align_buf_q[31:0];
    assign align_cnt_o   = align_cnt_q;

    // Bytes at or above align_cnt are always zero, so the append can simply OR in.
    always_comb begin
        remain      = align_cnt_q - {1'b0, consume_i};
        align_buf_d = align_buf_q >> {consume_i, 3'b000};
        align_cnt_d = remain;
        if (stream_read_o) begin
            align_buf_d = align_buf_d | ({32'd0, stream_data_i} << {remain, 3'b000});
            align_cnt_d = remain + 4'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            align_buf_q <= '0;
            align_cnt_q <= '0;
        end else begin
            align_buf_q <= align_buf_d;
            align_cnt_q <= align_cnt_d;
        end
    end

endmodule

// File: rtl/crc_calculator.sv
// CRC-16 x^16+x^12+x^5+1, LSB-first, over the low nbytes_i bytes (1..4) of data_i.
module crc_calculator (
    input  logic [15:0] crc_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;
    logic        fb;

    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes_i) begin
                for (int k = 0; k < 8; k++) begin
                    fb = c[0] ^ data_i[8*b+k];
                    c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
                end
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/ecc_calc.sv
// DSI packet header ECC over the 24-bit {wc, di} field; top two bits are zero.
module ecc_calc (
    input  logic [23:0] data_i,
    output logic [7:0]  ecc_o
);

    assign ecc_o[0] = ^(data_i & 24'hF12CB7);
    assign ecc_o[1] = ^(data_i & 24'hF2555B);
    assign ecc_o[2] = ^(data_i & 24'h749A6D);
    assign ecc_o[3] = ^(data_i & 24'hB8E38E);
    assign ecc_o[4] = ^(data_i & 24'hDF03F0);
    assign ecc_o[5] = ^(data_i & 24'hEFFC00);
    assign ecc_o[7:6] = 2'b00;

endmodule

// File: rtl/packets_splitter.sv
// Splits a gap-free bonded DSI byte stream into word-aligned headers and
// payload words, checking header ECC and long-packet CRC on the way.
module packets_splitter
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] stream_data,
    input  logic        stream_valid,
    output logic        stream_read,
    output logic [31:0] fifo_data,
    output logic [1:0]  fifo_tag,
    output logic [2:0]  fifo_bytes,
    output logic        fifo_write,
    input  logic        fifo_full,
    output logic        ecc_error,
    output logic        crc_error,
    output logic        packet_done
);

    split_state_e state_q, state_d;
    logic [15:0]  bytes_left_q, bytes_left_d;
    logic [15:0]  crc_q, crc_d;
    logic         ecc_err_q, ecc_err_d;
    logic         crc_err_q, crc_err_d;
    logic         done_q, done_d;

    logic [31:0]  align_word;
    logic [3:0]   align_cnt;
    logic [2:0]   need_n, consume_n, pay_n;
    logic         take;
    logic [7:0]   ecc_exp;
    logic [15:0]  crc_next;
    logic [15:0]  rx_wc;
    logic         rx_long;

    byte_aligner u_aligner (
        .clk            (clk),
        .reset_n        (reset_n),
        .stream_data_i  (stream_data),
        .stream_valid_i (stream_valid),
        .stream_read_o  (stream_read),
        .consume_i      (consume_n),
        .align_word_o   (align_word),
        .align_cnt_o    (align_cnt)
    );

    ecc_calc u_ecc (
        .data_i (align_word[23:0]),
        .ecc_o  (ecc_exp)
    );

    crc_calculator u_crc (
        .crc_i    (crc_q),
        .data_i   (align_word),
        .nbytes_i (pay_n),
        .crc_o    (crc_next)
    );

    assign rx_wc   = align_word[23:8];
    assign rx_long = is_long_type(align_word[7:0]);
    assign pay_n   = (bytes_left_q >= 16'd4) ? 3'd4 : bytes_left_q[2:0];

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        crc_d        = crc_q;
        ecc_err_d    = 1'b0;
        crc_err_d    = 1'b0;
        done_d       = 1'b0;
        need_n       = 3'd4;
        take         = 1'b0;
        fifo_write   = 1'b0;
        fifo_data    = '0;
        fifo_tag     = TAG_PAYLOAD;
        fifo_bytes   = '0;

        case (state_q)
            ST_HEADER: begin
                need_n = 3'd4;
                if (align_cnt >= 4'd4) begin
                    fifo_data  = align_word;
                    fifo_tag   = rx_long ? TAG_LONG : TAG_SHORT;
                    fifo_bytes = 3'd4;
                    fifo_write = !fifo_full;
                    take       = !fifo_full;
                end
                if (take) begin
                    ecc_err_d = (ecc_exp != align_word[31:24]);
                    if (rx_long) begin
                        bytes_left_d = rx_wc;
                        crc_d        = CRC_INIT;
                        state_d      = (rx_wc != 16'd0) ? ST_PAYLOAD : ST_CRC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                need_n = pay_n;
                if (align_cnt >= {1'b0, pay_n}) begin
                    fifo_data  = align_word & byte_mask(pay_n);
                    fifo_bytes = pay_n;
                    fifo_write = !fifo_full;
                    take       = !fifo_full;
                end
                if (take) begin
                    crc_d        = crc_next;
                    bytes_left_d = bytes_left_q - {13'd0, pay_n};
                    if (bytes_left_d == 16'd0) state_d = ST_CRC;
                end
            end

            ST_CRC: begin
                // The trailing CRC never goes to the FIFO, so back-pressure is irrelevant here.
                need_n = 3'd2;
                take   = (align_cnt >= 4'd2);
                if (take) begin
                    crc_err_d = (align_word[15:0] != crc_q);
                    done_d    = 1'b1;
                    state_d   = ST_HEADER;
                end
            end

            default: state_d = ST_HEADER;
        endcase

        consume_n = take ? need_n : 3'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HEADER;
            bytes_left_q <= '0;
            crc_q        <= CRC_INIT;
            ecc_err_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            crc_q        <= crc_d;
            ecc_err_q    <= ecc_err_d;
            crc_err_q    <= crc_err_d;
            done_q       <= done_d;
        end
    end

    assign ecc_error   = ecc_err_q;
    assign crc_error   = crc_err_q;
    assign packet_done = done_q;

endmodule

// File: tb/tb_packets_splitter.sv
// Directed bench for packets_splitter: a byte-queue stream driver, a FIFO/pulse
// monitor, a packet table with a bench-side ECC/CRC model, and corner sequences.
module tb_packets_splitter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] stream_data = '0;
    logic        stream_valid = 1'b0;
    logic        stream_read;
    logic [31:0] fifo_data;
    logic [1:0]  fifo_tag;
    logic [2:0]  fifo_bytes;
    logic        fifo_write;
    logic        fifo_full = 1'b0;
    logic        ecc_error, crc_error, packet_done;

    always #5 clk = ~clk;

    packets_splitter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_read  (stream_read),
        .fifo_data    (fifo_data),
        .fifo_tag     (fifo_tag),
        .fifo_bytes   (fifo_bytes),
        .fifo_write   (fifo_write),
        .fifo_full    (fifo_full),
        .ecc_error    (ecc_error),
        .crc_error    (crc_error),
        .packet_done  (packet_done)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  tag;
        logic [2:0]  bytes;
        int          cyc;
    } wr_t;

    typedef struct {
        logic ecc;
        logic crc;
        int   cyc;
    } ev_t;

    typedef struct {
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  pbase;
        logic        crc_bad;
        logic [23:0] flip;
        logic        exp_ecc;
        logic        exp_crc;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] sq[$];
    wr_t  wrq[$];
    wr_t  expq[$];
    ev_t  evq[$];
    int   n_ecc = 0, n_crc = 0, cyc = 0;
    logic ecc_acc = 1'b0;
    bit   drv_acc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ecc_of(input logic [23:0] d);
        logic [5:0] col [24];
        logic [5:0] p;
        col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        p = '0;
        for (int i = 0; i < 24; i++) if (d[i]) p ^= col[i];
        return {2'b00, p};
    endfunction

    // Byte-wise reflected CCITT update (0x8408 form), seed 0xFFFF.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [7:0] x;
        x = b ^ crc[7:0];
        x = x ^ (x << 4);
        return ({x, 8'h00} | {8'h00, crc[15:8]}) ^ {12'h000, x[7:4]} ^ ({8'h00, x} << 3);
    endfunction

    function automatic wr_t get_wr(input int i);
        wr_t w;
        w = '{data: '0, tag: '0, bytes: '0, cyc: 0};
        if (i < wrq.size()) w = wrq[i];
        return w;
    endfunction

    // Appends one packet to the stream and its expected FIFO writes to expq.
    task automatic push_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] pbase,
                            input logic crc_bad, input logic [23:0] flip);
        logic [23:0] h, ht;
        logic [7:0]  e, b;
        logic [15:0] c, rwc;
        logic [31:0] w;
        logic        lng;
        int          nb;
        h   = {wc[15:8], wc[7:0], di};
        e   = ecc_of(h);
        ht  = h ^ flip;
        lng = (ht[7:2] == 6'h0E) || (ht[7:2] == 6'h09);
        sq.push_back(ht[7:0]); sq.push_back(ht[15:8]); sq.push_back(ht[23:16]); sq.push_back(e);
        expq.push_back('{data: {e, ht}, tag: lng ? 2'b10 : 2'b01, bytes: 3'd4, cyc: 0});
        if (lng) begin
            rwc = ht[23:8];
            c = 16'hFFFF;
            w = '0;
            nb = 0;
            for (int k = 0; k < int'(rwc); k++) begin
                b = pbase + 8'(k);
                sq.push_back(b);
                c = crc_byte(c, b);
                w[8*nb +: 8] = b;
                nb++;
                if (nb == 4 || k == int'(rwc) - 1) begin
                    expq.push_back('{data: w, tag: 2'b00, bytes: 3'(nb), cyc: 0});
                    w = '0;
                    nb = 0;
                end
            end
            if (crc_bad) c = c ^ 16'h0001;
            sq.push_back(c[7:0]);
            sq.push_back(c[15:8]);
        end
    endtask

    task automatic pad4();
        while (sq.size() % 4 != 0) sq.push_back(8'h00);
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (sq.size() != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check("stream_drain", 64'(sq.size()), 64'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_wr(input int n, input int maxc);
        int k;
        @(negedge clk);
        k = 1;
        while (wrq.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check("wait_writes", 64'(wrq.size() >= n), 64'd1);
    endtask

    task automatic clear_obs();
        wrq.delete();
        evq.delete();
        expq.delete();
        n_ecc = 0;
        n_crc = 0;
        ecc_acc = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        fifo_full = 1'b0;
        sq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_obs();
    endtask

    task automatic cmp_writes(input string tag);
        wr_t g;
        check({tag, "_nwrites"}, 64'(wrq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            g = get_wr(i);
            check($sformatf("%s_wr%0d", tag, i), {g.data, g.tag, g.bytes},
                  {expq[i].data, expq[i].tag, expq[i].bytes});
        end
    endtask

    // Stream driver: presents 4 queued bytes, pops them once the word was accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (drv_acc) repeat (4) if (sq.size() > 0) void'(sq.pop_front());
            #1;
            if (sq.size() >= 4) begin
                stream_valid = 1'b1;
                stream_data  = {sq[3], sq[2], sq[1], sq[0]};
            end else begin
                stream_valid = 1'b0;
                stream_data  = '0;
            end
            #1 drv_acc = stream_valid && stream_read;
        end
    end

    // Monitor: samples between the input updates and the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (fifo_write) wrq.push_back('{data: fifo_data, tag: fifo_tag, bytes: fifo_bytes, cyc: cyc});
            if (ecc_error) n_ecc++;
            if (crc_error) n_crc++;
            if (packet_done) begin
                evq.push_back('{ecc: ecc_acc | ecc_error, crc: crc_error, cyc: cyc});
                ecc_acc = 1'b0;
            end else if (ecc_error) begin
                ecc_acc = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [8];
        wr_t  g;
        int   base;
        int   e_ecc, e_crc;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_stream_read", 64'(stream_read), 64'd0);
        check("rst_fifo_write", 64'(fifo_write), 64'd0);
        check("rst_fifo_data", 64'(fifo_data), 64'd0);
        check("rst_fifo_tag_bytes", {fifo_tag, fifo_bytes}, 64'd0);
        check("rst_pulses", {ecc_error, crc_error, packet_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_obs();

        // Short header, then long DI 0x39 WC 5, then a short header at byte offset 3
        push_pkt(8'h05, 16'h1234, 8'h00, 1'b0, 24'h0);
        push_pkt(8'h39, 16'd5, 8'h01, 1'b0, 24'h0);
        push_pkt(8'h15, 16'hABCD, 8'h00, 1'b0, 24'h0);
        pad4();
        wait_idle(200);
        check("seq_nwrites", 64'(wrq.size()), 64'd5);
        g = get_wr(0);
        check("short_hdr", {g.data, g.tag, g.bytes}, {ecc_of(24'h123405), 24'h123405, 2'b01, 3'd4});
        check("short_done_latency", 64'(evq.size() > 0 ? evq[0].cyc : -1), 64'(g.cyc + 1));
        g = get_wr(1);
        check("long_hdr", {g.data, g.tag, g.bytes}, {ecc_of(24'h000539), 24'h000539, 2'b10, 3'd4});
        g = get_wr(2);
        check("long_pay0", {g.data, g.tag, g.bytes}, {32'h04030201, 2'b00, 3'd4});
        g = get_wr(3);
        check("long_pay1", {g.data, g.tag, g.bytes}, {32'h00000005, 2'b00, 3'd1});
        g = get_wr(4);
        check("offset3_hdr", {g.data, g.tag, g.bytes}, {ecc_of(24'hABCD15), 24'hABCD15, 2'b01, 3'd4});
        check("seq_done_count", 64'(evq.size()), 64'd3);
        check("seq_err_counts", {32'(n_ecc), 32'(n_crc)}, 64'd0);

        // Packet table, streamed back to back
        do_reset();
        vt[0] = '{8'h05, 16'h1234, 8'h00, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[1] = '{8'h39, 16'd5,    8'h01, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[2] = '{8'h15, 16'h0000, 8'h00, 1'b0, 24'h000800, 1'b1, 1'b0};
        vt[3] = '{8'h24, 16'd0,    8'h00, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[4] = '{8'h3A, 16'd7,    8'h10, 1'b1, 24'h000000, 1'b0, 1'b1};
        vt[5] = '{8'h27, 16'd2,    8'hA0, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[6] = '{8'h29, 16'hBEEF, 8'h00, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[7] = '{8'h38, 16'd3,    8'hF0, 1'b0, 24'h000000, 1'b0, 1'b0};
        e_ecc = 0;
        e_crc = 0;
        for (int i = 0; i < 8; i++) begin
            push_pkt(vt[i].di, vt[i].wc, vt[i].pbase, vt[i].crc_bad, vt[i].flip);
            e_ecc += int'(vt[i].exp_ecc);
            e_crc += int'(vt[i].exp_crc);
        end
        pad4();
        wait_idle(400);
        check("tbl_done_count", 64'(evq.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tbl%0d_ecc", i), 64'(i < evq.size() ? evq[i].ecc : 1'bx), 64'(vt[i].exp_ecc));
            check($sformatf("tbl%0d_crc", i), 64'(i < evq.size() ? evq[i].crc : 1'bx), 64'(vt[i].exp_crc));
        end
        check("tbl_ecc_pulses", 64'(n_ecc), 64'(e_ecc));
        check("tbl_crc_pulses", 64'(n_crc), 64'(e_crc));
        cmp_writes("tbl");

        // Back-pressure in the middle of a WC 64 payload
        do_reset();
        push_pkt(8'h39, 16'd64, 8'h40, 1'b0, 24'h0);
        push_pkt(8'h05, 16'h0042, 8'h00, 1'b0, 24'h0);
        pad4();
        wait_wr(3, 100);
        fifo_full = 1'b1;
        base = wrq.size();
        repeat (10) @(negedge clk);
        #1;
        check("bp_no_writes", 64'(wrq.size()), 64'(base));
        check("bp_write_low", 64'(fifo_write), 64'd0);
        check("bp_read_low", 64'(stream_read), 64'd0);
        fifo_full = 1'b0;
        wait_idle(300);
        cmp_writes("bp");
        check("bp_done_count", 64'(evq.size()), 64'd2);
        check("bp_err_counts", {32'(n_ecc), 32'(n_crc)}, 64'd0);

        // Reset in the middle of a payload
        do_reset();
        push_pkt(8'h39, 16'd64, 8'h00, 1'b0, 24'h0);
        pad4();
        wait_wr(4, 100);
        reset_n = 1'b0;
        sq.delete();
        #1;
        check("mid_rst_read_write", {stream_read, fifo_write}, 64'd0);
        check("mid_rst_data", 64'(fifo_data), 64'd0);
        check("mid_rst_tag_bytes", {fifo_tag, fifo_bytes}, 64'd0);
        check("mid_rst_pulses", {ecc_error, crc_error, packet_done}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_obs();
        push_pkt(8'h05, 16'h1234, 8'h00, 1'b0, 24'h0);
        pad4();
        wait_idle(100);
        cmp_writes("post_rst");
        check("post_rst_done", 64'(evq.size()), 64'd1);
        check("post_rst_errs", {32'(n_ecc), 32'(n_crc)}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packets_splitter.md
# packets_splitter

Receive-side counterpart of the DSI packet bonding stage. It takes a gap-free 32-bit byte stream of bonded DSI packets, in which packets start at any byte offset, and realigns it into word-aligned headers and payload words for a downstream FIFO. It also checks the header ECC and the long-packet CRC. It sits after the lane deserialiser/merger (or in loopback, directly after the bonder) and feeds the packet-consuming logic.

## Interface
- Parameters: none. Long-packet classification, ECC and CRC are fixed by the shared DSI package.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `stream_data` in 32: stream bytes; byte 0 (earliest) in [7:0].
- `stream_valid` in 1: `stream_data` is valid.
- `stream_read` out 1: word consumed this cycle (only when `stream_valid`).
- `fifo_data` out 32: header word `{ecc, wc[15:8], wc[7:0], di}` or a payload word, zero-padded above the valid bytes.
- `fifo_tag` out 2: 2'b01 short header, 2'b10 long header, 2'b00 payload.
- `fifo_bytes` out 3: valid bytes in `fifo_data`, range 1..4; always 4 for headers.
- `fifo_write` out 1: write strobe.
- `fifo_full` in 1: downstream full; no write occurs while it is high.
- `ecc_error` out 1: one-cycle pulse when the header ECC mismatches.
- `crc_error` out 1: one-cycle pulse when the long-packet CRC mismatches.
- `packet_done` out 1: one-cycle pulse at the end of each packet.

## Operation
- **Align buffer.** 64-bit `align_buf` plus byte count `align_cnt` (0..8).
  - `stream_read = stream_valid && align_cnt <= 4 && reset_n`.
  - An accepted word is appended at byte position `align_cnt - consumed`, where `consumed` is the bytes removed in the same cycle. The buffer is shifted down by `consumed*8`.
- **Consumption.** At most one consumption of `n` bytes per cycle. It happens only when `align_cnt >= n` and, for writing states, `!fifo_full`.
- **HEADER state** (reset state), `n = 4`.
  - Drives `fifo_data = align_buf[31:0]`, `fifo_write = 1`, tag 01 or 10.
  - Long iff `di[7:2]` is 6'h0E or 6'h09; this is the package function shared with the transmitter.
  - Computes ECC over [23:0] through `ecc_calc` and compares it with [31:24]. Detection only, no correction; the received WC is used regardless.
  - Short packet: stay in HEADER and pulse `packet_done`.
  - Long packet: load `bytes_left = wc` and clear the CRC to 16'hFFFF. Go to PAYLOAD if `wc != 0`, else go to CRC.
- **PAYLOAD state**, `n = min(4, bytes_left)`.
  - Writes the low `n` bytes, zero-padded, with `fifo_bytes = n` and tag 00.
  - CRC is updated over the same `n` bytes.
  - `bytes_left -= n` (16-bit, never underflows). Go to CRC when it reaches 0.
- **CRC state**, `n = 2`, no FIFO write.
  - Received CRC is `{buf[15:8], buf[7:0]}`, low byte first.
  - Mismatch pulses `crc_error`; `packet_done` pulses in all cases. Go to HEADER.
- **CRC definition.** CRC-16 x^16+x^12+x^5+1, init 16'hFFFF, LSB-first, from the existing `crc_calculator` (1..4 bytes per call). An empty payload yields 16'hFFFF.
- **Boundary behaviour.**
  - `stream_valid` low: buffer holds and no state advances unless enough bytes are already buffered.
  - `fifo_full` in HEADER/PAYLOAD: holds, and the buffer fills to at most 8 bytes, then `stream_read` drops. No byte is lost or reordered.
  - CRC state ignores `fifo_full`.
  - Accept and consume in the same cycle is legal at every `align_cnt`.
  - Reset mid-packet: FSM to HEADER, buffer emptied, partial packet discarded, no pulses emitted.

## Timing
- Reset values:
  - `stream_read` 0, `fifo_write` 0.
  - `fifo_data` 0, `fifo_tag` 0, `fifo_bytes` 0.
  - `ecc_error` 0, `crc_error` 0, `packet_done` 0.
  - `align_cnt` 0, FSM HEADER.
- Combinational outputs: `fifo_write`, `fifo_data`, `fifo_tag`, `fifo_bytes` are driven from registered state and `fifo_full`; there is no extra pipeline stage.
- Latency: a word accepted at cycle t can be written at t+1.
- `ecc_error`, `crc_error` and `packet_done` are registered, asserted the cycle after the causing consumption, for exactly one cycle.
- Throughput: one FIFO word per cycle in steady state. Each CRC state costs one cycle without a write.

## Structure
- Shared package `dsi_pkg` holds:
  - `is_long_type(di)`;
  - FSM state encoding (HEADER, PAYLOAD, CRC);
  - tag constants;
  - CRC init value 16'hFFFF.
- Reused sub-modules: `ecc_calc` (combinational) and `crc_calculator`.
- One natural new sub-module: `byte_aligner`, which owns the align buffer, append/shift logic and `stream_read`.

## Test plan
- **Short header.** Word {ECC(0x123405), 0x12, 0x34, 0x05} -> one write, tag 01, data matches the word; `packet_done` at +1; no `ecc_error`.
- **Long packet, unaligned follow-on.** DI 0x39, WC 5, payload 01..05, valid CRC, followed by a short header at stream byte offset 3 -> writes, in order:
  - header, tag 10;
  - 0x04030201, bytes 4;
  - 0x00000005, bytes 1;
  - the short header, correctly aligned.
  No `crc_error`.
- **Bad CRC.** Same packet with the CRC low byte XOR 0x01 -> `crc_error` and `packet_done` both pulse once, same cycle; next packet unaffected.
- **Bad ECC.** Flip WC bit 3 in a short header -> `ecc_error` pulse; header still written unmodified.
- **Empty long packet.** WC 0 with CRC 0xFFFF -> header only, zero payload writes, `packet_done`, no `crc_error`.
- **Back-pressure and reset.**
  - `fifo_full` held 10 cycles mid-payload of WC 64 -> no writes, `stream_read` low once `align_cnt > 4`, payload intact after release.
  - Reset asserted mid-payload -> all outputs 0, next header parsed cleanly.
